fetch_sequencer: RTL and testbench

//  Owns the program counter and sequences instruction fetch over a req/ack instruction-memory port.

---
 rtl/fetch_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter and sequences instruction fetch
// over a req/ack instruction-memory port.
// Next-PC priority: trap vector > branch/jump redirect > stall hold > PC+4.
// Wrong-path fetches are discarded, and fetches that wait too long raise a
// sticky timeout and park the sequencer until a trap arrives.
// Optional feature macro: PC_MISALIGN_TRAP_EN -- a redirect to a non-word-aligned
// target pulses misalign_err_o and fetches TRAP_VECTOR instead of the target.
// Without the macro, targets are truncated to word alignment and
// misalign_err_o stays 0.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h8000_0180,
  parameter int          MAX_WAIT     = 8
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic        trap_req_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_out_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] pc_out_o,
  output logic        timeout_err_o,
  output logic        misalign_err_o
);

  // Wide enough to hold MAX_WAIT-1, the last count before a timeout.
  localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  state_e         state_q;
  logic [31:0]    pc_q;
  logic           req_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           inst_valid_q;
  logic [31:0]    inst_out_q;
  logic [31:0]    inst_pc_q;
  logic           timeout_q;
  logic           misalign_q;
  logic           pend_q;
  logic           pend_trap_q;
  logic [31:0]    pend_addr_q;

  logic [31:0]    redir_addr;
  logic           misaligned;
  logic           new_hit;
  logic [31:0]    new_addr;
  logic           any_redir;
  logic [31:0]    redir_target_d;
  logic           redir_is_trap_d;
  logic           misalign_d;

  // Resolve the address a redirect request would load, honouring alignment.
  always_comb begin
    misaligned = 1'b0;
    redir_addr = {redirect_target_i[31:2], 2'b00};
`ifdef PC_MISALIGN_TRAP_EN
    misaligned = (redirect_target_i[1:0] != 2'b00);
    if (misaligned) begin
      redir_addr = TRAP_VECTOR;
    end
`else
    // Low target bits are simply dropped; they only feed a zero here.
    redir_addr = {redirect_target_i[31:2], redirect_target_i[1:0] & 2'b00};
`endif
  end

  // Pick the winning redirect source: incoming trap, pending trap,
  // incoming redirect, then pending redirect.
  always_comb begin
    new_hit         = trap_req_i | redirect_valid_i;
    new_addr        = trap_req_i ? TRAP_VECTOR : redir_addr;
    any_redir       = new_hit | pend_q;
    redir_target_d  = pend_addr_q;
    redir_is_trap_d = pend_trap_q;
    if (trap_req_i) begin
      redir_target_d  = TRAP_VECTOR;
      redir_is_trap_d = 1'b1;
    end else if (pend_q && pend_trap_q) begin
      redir_target_d  = pend_addr_q;
      redir_is_trap_d = 1'b1;
    end else if (redirect_valid_i) begin
      redir_target_d  = redir_addr;
      redir_is_trap_d = 1'b0;
    end
    // A misaligned redirect only reports when it is actually accepted.
    misalign_d = redirect_valid_i & ~trap_req_i & misaligned &
                 ((state_q == S_FETCH) | (state_q == S_HOLD));
  end

  // Fetch state machine with PC, pending-redirect and delivery registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VECTOR;
      req_q        <= 1'b0;
      wait_cnt_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      timeout_q    <= 1'b0;
      misalign_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_trap_q  <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      inst_valid_q <= 1'b0;
      misalign_q   <= misalign_d;
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack_i) begin
            wait_cnt_q <= '0;
            pend_q     <= 1'b0;
            if (any_redir) begin
              // Wrong-path fetch: drop the data, restart at the new target.
              pc_q <= redir_target_d;
            end else begin
              inst_valid_q <= 1'b1;
              inst_out_q   <= imem_rdata_i;
              inst_pc_q    <= pc_q;
              pc_q         <= pc_q + 32'd4;
            end
            if (stall_i) begin
              state_q <= S_HOLD;
              req_q   <= 1'b0;
            end else begin
              state_q <= S_FETCH;
              req_q   <= 1'b1;
            end
          end else begin
            // Address must stay stable while the request is outstanding,
            // so redirects are parked until the ack arrives.
            if (new_hit) begin
              pend_q      <= 1'b1;
              pend_trap_q <= redir_is_trap_d;
              pend_addr_q <= redir_target_d;
            end
            if (wait_cnt_q == WAIT_LAST) begin
              state_q    <= S_ERR;
              req_q      <= 1'b0;
              timeout_q  <= 1'b1;
              wait_cnt_q <= '0;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          // No request is outstanding, so the PC may move right away.
          if (new_hit) begin
            pc_q <= new_addr;
          end
          if (!stall_i) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end
        end
        S_ERR: begin
          if (trap_req_i || (pend_q && pend_trap_q)) begin
            pc_q       <= TRAP_VECTOR;
            pend_q     <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= S_FETCH;
            req_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o     = req_q;
  assign imem_addr_o    = pc_q;
  assign pc_out_o       = pc_q;
  assign inst_valid_o   = inst_valid_q;
  assign inst_out_o     = inst_out_q;
  assign inst_pc_o      = inst_pc_q;
  assign timeout_err_o  = timeout_q;
  assign misalign_err_o = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: reset, streaming fetch, delayed ack,
// redirect/trap discard, stall hold, timeout recovery and PC wrap/alignment.
module tb_fetch_sequencer;

  localparam logic [31:0] KEY = 32'h5A5A_C3C3;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] pc_out;
  logic        timeout_err;
  logic        misalign_err;

  int total;
  int bad;

  fetch_sequencer dut (
    .clock_i          (clock),
    .reset_ni         (reset_n),
    .stall_i          (stall),
    .redirect_valid_i (redirect_valid),
    .redirect_target_i(redirect_target),
    .trap_req_i       (trap_req),
    .imem_req_o       (imem_req),
    .imem_addr_o      (imem_addr),
    .imem_ack_i       (imem_ack),
    .imem_rdata_i     (imem_rdata),
    .inst_valid_o     (inst_valid),
    .inst_out_o       (inst_out),
    .inst_pc_o        (inst_pc),
    .pc_out_o         (pc_out),
    .timeout_err_o    (timeout_err),
    .misalign_err_o   (misalign_err)
  );

  // Memory model: instruction word is its address scrambled with a key.
  assign imem_rdata = imem_addr ^ KEY;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    trap_req = 1'b0; imem_ack = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    imem_ack = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    total++; if (imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, 32'h0040_0000); end
    total++; if (pc_out !== 32'h0040_0000) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc_out, 32'h0040_0000); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", inst_valid); end
    total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
    total++; if (inst_out !== 32'h0) begin bad++; $display("FAIL rst_inst_out got=%h exp=0", inst_out); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", timeout_err); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b exp=0", misalign_err); end
    $display("reset: addr=%h req=%b valid=%b", imem_addr, imem_req, inst_valid);
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    do_reset();
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 32'h0040_0000 + 32'(4 * i);
      total++; if (imem_addr !== exp_addr) begin bad++; $display("FAIL stream_addr%0d got=%h exp=%h", i, imem_addr, exp_addr); end
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stream_req%0d got=%b exp=1", i, imem_req); end
      tick();
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL stream_valid%0d got=%b exp=1", i, inst_valid); end
      total++; if (inst_pc !== exp_addr) begin bad++; $display("FAIL stream_pc%0d got=%h exp=%h", i, inst_pc, exp_addr); end
      total++; if (inst_out !== (exp_addr ^ KEY)) begin bad++; $display("FAIL stream_inst%0d got=%h exp=%h", i, inst_out, exp_addr ^ KEY); end
      $display("stream: fetch %0d pc=%h inst=%h", i, inst_pc, inst_out);
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_delayed_ack();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      total++; if (imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL delay_addr%0d got=%h exp=%h", i, imem_addr, 32'h0040_0000); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL delay_valid%0d got=%b exp=0", i, inst_valid); end
      if (i == 3) imem_ack = 1'b1;
      tick();
    end
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL delay_pulse got=%b exp=1", inst_valid); end
    total++; if (inst_pc !== 32'h0040_0000) begin bad++; $display("FAIL delay_pc got=%h exp=%h", inst_pc, 32'h0040_0000); end
    total++; if (imem_addr !== 32'h0040_0004) begin bad++; $display("FAIL delay_next got=%h exp=%h", imem_addr, 32'h0040_0004); end
    imem_ack = 1'b0;
    tick();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL delay_single got=%b exp=0", inst_valid); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL delay_timeout got=%b exp=0", timeout_err); end
    $display("delayed_ack: next addr=%h", imem_addr);
  endtask

  task automatic test_redirect_wait();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'h0040_1000;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL redir_hold1 got=%h exp=%h", imem_addr, 32'h0040_0000); end
    tick();
    total++; if (imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL redir_hold2 got=%h exp=%h", imem_addr, 32'h0040_0000); end
    imem_ack = 1'b1;
    tick();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_discard got=%b exp=0", inst_valid); end
    total++; if (imem_addr !== 32'h0040_1000) begin bad++; $display("FAIL redir_addr got=%h exp=%h", imem_addr, 32'h0040_1000); end
    tick();
    total++; if (inst_pc !== 32'h0040_1000 || inst_valid !== 1'b1) begin bad++; $display("FAIL redir_deliver got=%h/%b exp=%h/1", inst_pc, inst_valid, 32'h0040_1000); end
    imem_ack = 1'b0;
    $display("redirect_wait: addr=%h inst_pc=%h", imem_addr, inst_pc);
  endtask

  task automatic test_trap_priority();
    do_reset();
    trap_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0040_1000; imem_ack = 1'b1;
    tick();
    trap_req = 1'b0; redirect_valid = 1'b0;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL trap_discard got=%b exp=0", inst_valid); end
    total++; if (imem_addr !== 32'h8000_0180) begin bad++; $display("FAIL trap_addr got=%h exp=%h", imem_addr, 32'h8000_0180); end
    tick();
    total++; if (inst_pc !== 32'h8000_0180) begin bad++; $display("FAIL trap_pc got=%h exp=%h", inst_pc, 32'h8000_0180); end
    total++; if (imem_addr !== 32'h8000_0184) begin bad++; $display("FAIL trap_next got=%h exp=%h", imem_addr, 32'h8000_0184); end
    imem_ack = 1'b0;
    $display("trap_priority: addr=%h", imem_addr);
  endtask

  task automatic test_stall_hold();
    do_reset();
    imem_ack = 1'b1; stall = 1'b1;
    tick();
    imem_ack = 1'b0;
    total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", inst_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== 32'h0040_0004) begin bad++; $display("FAIL hold_addr got=%h exp=%h", imem_addr, 32'h0040_0004); end
    redirect_valid = 1'b1; redirect_target = 32'h0040_2000;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 32'h0040_2000) begin bad++; $display("FAIL hold_redir got=%h exp=%h", imem_addr, 32'h0040_2000); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_stay got=%b exp=0", imem_req); end
    stall = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL hold_exit got=%b exp=1", imem_req); end
    $display("stall_hold: addr=%h req=%b", imem_addr, imem_req);
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL to_req%0d got=%b exp=1", i, imem_req); end
      tick();
    end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL to_err_req got=%b exp=0", imem_req); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_flag got=%b exp=1", timeout_err); end
    total++; if (imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL to_pc got=%h exp=%h", imem_addr, 32'h0040_0000); end
    tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL to_park got=%b exp=0", imem_req); end
    trap_req = 1'b1;
    tick();
    trap_req = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0180) begin bad++; $display("FAIL to_recover got=%b/%h exp=1/%h", imem_req, imem_addr, 32'h8000_0180); end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    total++; if (inst_pc !== 32'h8000_0180) begin bad++; $display("FAIL to_deliver got=%h exp=%h", inst_pc, 32'h8000_0180); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
    $display("timeout: flag=%b addr=%h", timeout_err, imem_addr);
  endtask

  task automatic test_wrap_align();
    logic [31:0] exp_mis_addr;
    logic        exp_mis;
`ifdef PC_MISALIGN_TRAP_EN
    exp_mis_addr = 32'h8000_0180; exp_mis = 1'b1;
`else
    exp_mis_addr = 32'h0040_1000; exp_mis = 1'b0;
`endif
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; imem_ack = 1'b1;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_load got=%h exp=%h", imem_addr, 32'hFFFF_FFFC); end
    tick();
    total++; if (imem_addr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
    total++; if (inst_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", inst_pc, 32'hFFFF_FFFC); end
    redirect_valid = 1'b1; redirect_target = 32'h0040_1002;
    tick();
    redirect_valid = 1'b0; imem_ack = 1'b0;
    total++; if (imem_addr !== exp_mis_addr) begin bad++; $display("FAIL align_addr got=%h exp=%h", imem_addr, exp_mis_addr); end
    total++; if (misalign_err !== exp_mis) begin bad++; $display("FAIL align_err got=%b exp=%b", misalign_err, exp_mis); end
    tick();
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL align_pulse got=%b exp=0", misalign_err); end
    $display("wrap_align: addr=%h misalign=%b", imem_addr, misalign_err);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_stream();
    test_delayed_ack();
    test_redirect_wait();
    test_trap_priority();
    test_stall_hold();
    test_timeout();
    test_wrap_align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
